dual_rail_gray_monitor: RTL
===========================

# dual_rail_gray_monitor

Receiving end of the dual-rail 4-variable stimulus bus that drives our combinational problem blocks. Samples true/complement rails (a..d, an..dn), checks rail integrity and unit-distance (Gray) stepping, decodes each word to its walk index 0..15, and flags any departure from the canonical reflected-Gray walk. Used beside a DUT to self-check exhaustive Gray-ordered stimulus.

## Interface
- CNT_W, 8, width of accepted-word counter (saturating)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample strobe; one word per asserted cycle
- a, b, c, d  in  1 each  true rails; a = MSB of the Gray word
- an, bn, cn, dn  in  1 each  complement rails
- clear  in  1  synchronous clear of state, counters, fault
- idx_valid  out  1  pulse: idx updated
- idx  out  4  binary walk index of last accepted word
- rail_err  out  1  pulse: some pair not complementary
- step_err  out  1  pulse: Hamming distance to previous word != 1
- seq_err  out  1  pulse: idx != expected next index
- fault  out  1  level: sticky, any error since reset/clear
- walk_done  out  1  pulse: 16 consecutive correct words, index 0..15
- word_count  out  CNT_W  rail-valid words since reset/clear, saturates at all-ones

## Operation
- Word g = {a,b,c,d}. Rail-valid iff a==~an, b==~bn, c==~cn, d==~dn.
- Decode: i3=g3, i2=i3^g2, i1=i2^g1, i0=i1^g0.
- Rail-invalid word: rail_err pulse, word discarded (idx, prev word, expected, word_count unchanged), state -> FAULT.
- States: IDLE (no word since reset/clear), TRACK, FAULT.
- IDLE + rail-valid word: accepted unconditionally, no step/seq check; expected <= idx+1 mod 16; run <= 1 if idx==0 else 0; -> TRACK.
- TRACK + rail-valid word: step_err if popcount(g ^ prev) != 1 (0 included); seq_err if idx != expected; both may assert together. Word always accepted (idx, prev, expected <= idx+1 mod 16 updated). Any error -> FAULT.
- Run counter (5 bits): in TRACK, correct word with idx==0 sets run=1; otherwise run increments when nonzero; run reaching 16 on idx==15 pulses walk_done and resets run to 0. Wrap 15 -> 0 is a legal step.
- FAULT: decoding, idx_valid, step/seq/rail pulses continue; walk_done suppressed; exits only via clear or reset.
- fault = (state == FAULT).
- word_count increments on every rail-valid in_valid word, saturating.
- clear: -> IDLE, word_count=0, run=0, fault=0; clear with in_valid same cycle: clear wins, word dropped.

## Timing
- All outputs registered; in_valid sampled at edge N, results visible after edge N (one-cycle latency).
- Pulses (idx_valid, rail_err, step_err, seq_err, walk_done) high exactly one cycle; low when in_valid low.
- Back-to-back in_valid every cycle supported, no stalls.
- Reset values: idx=0, idx_valid=0, all error pulses 0, fault=0, walk_done=0, word_count=0, state IDLE, prev=0, expected=0, run=0.
- Reset asserted mid-walk: all state cleared immediately (async); next word treated as first.

## Structure
- Package dual_rail_pkg: state enum {IDLE, TRACK, FAULT}; IDX_W=4; WALK_LEN=16; function gray2bin(4-bit); function popcount4.
- One sub-module natural: dual_rail_capture (pure combinational rail check + packing of {a,b,c,d} into g, rail_ok out). FSM, counters, checks in top.

## Test plan
- Full walk 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, complements correct, one word per 20 cycles -> idx 0..15 in order, no errors, walk_done one cycle after 16th word, word_count=16, fault=0.
- After prior walk, send a=1,an=1 (rest valid) -> rail_err pulse, fault=1, idx and word_count unchanged.
- From reset: 0000 then 0011 -> second word: step_err=1, seq_err=1, idx=2, fault=1; continue correct walk -> no walk_done.
- 0000, 0001, 0001 -> third word: step_err=1 (distance 0), seq_err=1 (expected 2), idx=1.
- Two full walks back-to-back (1000 -> 0000 wrap) -> no errors, walk_done pulses twice, word_count=32; start at 0011 from IDLE -> no error but walk_done only after a later run from 0000.
- Reset mid-walk at word 7, then 0000 -> clean restart, idx=0, no errors; clear coincident with in_valid -> word dropped, word_count=0, fault=0, state IDLE.

Source files
------------

// File: rtl/dual_rail_gray_monitor_pkg.sv
// Shared types and helpers for the dual-rail Gray walk monitor.
// Gray-to-binary decode and 4-bit popcount are used by the top-level checker.
package dual_rail_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StFault
  } state_e;

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned WALK_LEN = 16;

  function automatic logic [IDX_W-1:0] gray2bin(input logic [IDX_W-1:0] g);
    logic [IDX_W-1:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/dual_rail_gray_monitor_if.sv
// Stimulus rails in, decoded index / error flags / counters out.
// The master modport drives the rails; the slave modport is the monitor.
interface dual_rail_gray_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  import dual_rail_pkg::*;

  logic             in_valid;
  logic             a, b, c, d;
  logic             an, bn, cn, dn;
  logic             clear;
  logic             idx_valid;
  logic [IDX_W-1:0] idx;
  logic             rail_err;
  logic             step_err;
  logic             seq_err;
  logic             fault;
  logic             walk_done;
  logic [CNT_W-1:0] word_count;

  modport master (
    output in_valid, a, b, c, d, an, bn, cn, dn, clear,
    input  idx_valid, idx, rail_err, step_err, seq_err, fault, walk_done, word_count
  );

  modport slave (
    input  in_valid, a, b, c, d, an, bn, cn, dn, clear,
    output idx_valid, idx, rail_err, step_err, seq_err, fault, walk_done, word_count
  );

endinterface

// File: rtl/dual_rail_gray_monitor_capture.sv
// Packs the true rails into a Gray word (a = MSB) and checks that every
// true/complement pair is complementary.
module dual_rail_capture (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_c,
  input  logic       i_d,
  input  logic       i_an,
  input  logic       i_bn,
  input  logic       i_cn,
  input  logic       i_dn,
  output logic [3:0] o_g,
  output logic       o_rail_ok
);

  assign o_g       = {i_a, i_b, i_c, i_d};
  assign o_rail_ok = &({i_a, i_b, i_c, i_d} ^ {i_an, i_bn, i_cn, i_dn});

endmodule

// File: rtl/dual_rail_gray_monitor.sv
// Dual-rail Gray stimulus monitor: rail integrity, unit-distance stepping and
// canonical reflected-Gray walk checking, with sticky fault and walk counting.
module dual_rail_gray_monitor
  import dual_rail_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  dual_rail_gray_monitor_if.slave bus
);

  logic [3:0]       w_g;
  logic             w_rail_ok;
  logic [IDX_W-1:0] w_dec;
  logic             w_step_bad;
  logic             w_seq_bad;

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [3:0]       r_prev, w_prev_nxt;
  logic [IDX_W-1:0] r_expected, w_expected_nxt;
  logic [4:0]       r_run, w_run_nxt;
  logic [CNT_W-1:0] r_word_count, w_word_count_nxt;
  logic             r_idx_valid, w_idx_valid_nxt;
  logic             r_rail_err, w_rail_err_nxt;
  logic             r_step_err, w_step_err_nxt;
  logic             r_seq_err, w_seq_err_nxt;
  logic             r_walk_done, w_walk_done_nxt;

  dual_rail_capture u_capture (
    .i_a       (bus.a),
    .i_b       (bus.b),
    .i_c       (bus.c),
    .i_d       (bus.d),
    .i_an      (bus.an),
    .i_bn      (bus.bn),
    .i_cn      (bus.cn),
    .i_dn      (bus.dn),
    .o_g       (w_g),
    .o_rail_ok (w_rail_ok)
  );

  assign w_dec      = gray2bin(w_g);
  assign w_step_bad = popcount4(w_g ^ r_prev) != 3'd1;
  assign w_seq_bad  = w_dec != r_expected;

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_prev_nxt       = r_prev;
    w_expected_nxt   = r_expected;
    w_run_nxt        = r_run;
    w_word_count_nxt = r_word_count;
    w_idx_valid_nxt  = 1'b0;
    w_rail_err_nxt   = 1'b0;
    w_step_err_nxt   = 1'b0;
    w_seq_err_nxt    = 1'b0;
    w_walk_done_nxt  = 1'b0;

    if (bus.clear) begin
      // Clear beats a coincident word: the word is dropped entirely.
      w_state_nxt      = StIdle;
      w_word_count_nxt = '0;
      w_run_nxt        = '0;
      w_prev_nxt       = '0;
      w_expected_nxt   = '0;
    end else if (bus.in_valid) begin
      if (!w_rail_ok) begin
        w_rail_err_nxt = 1'b1;
        w_state_nxt    = StFault;
      end else begin
        if (r_word_count != '1) w_word_count_nxt = r_word_count + 1'b1;
        w_idx_valid_nxt = 1'b1;
        w_idx_nxt       = w_dec;
        w_prev_nxt      = w_g;
        w_expected_nxt  = w_dec + 4'd1;
        unique case (r_state)
          StIdle: begin
            w_run_nxt   = (w_dec == '0) ? 5'd1 : 5'd0;
            w_state_nxt = StTrack;
          end
          StTrack: begin
            w_step_err_nxt = w_step_bad;
            w_seq_err_nxt  = w_seq_bad;
            if (w_step_bad || w_seq_bad) begin
              w_state_nxt = StFault;
              w_run_nxt   = '0;
            end else if (w_dec == '0) begin
              w_run_nxt = 5'd1;
            end else if (r_run != '0) begin
              if (r_run == 5'(WALK_LEN - 1) && w_dec == 4'hF) begin
                w_walk_done_nxt = 1'b1;
                w_run_nxt       = '0;
              end else begin
                w_run_nxt = r_run + 5'd1;
              end
            end
          end
          StFault: begin
            w_step_err_nxt = w_step_bad;
            w_seq_err_nxt  = w_seq_bad;
          end
          default: w_state_nxt = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_prev       <= '0;
      r_expected   <= '0;
      r_run        <= '0;
      r_word_count <= '0;
      r_idx_valid  <= 1'b0;
      r_rail_err   <= 1'b0;
      r_step_err   <= 1'b0;
      r_seq_err    <= 1'b0;
      r_walk_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_prev       <= w_prev_nxt;
      r_expected   <= w_expected_nxt;
      r_run        <= w_run_nxt;
      r_word_count <= w_word_count_nxt;
      r_idx_valid  <= w_idx_valid_nxt;
      r_rail_err   <= w_rail_err_nxt;
      r_step_err   <= w_step_err_nxt;
      r_seq_err    <= w_seq_err_nxt;
      r_walk_done  <= w_walk_done_nxt;
    end
  end

  assign bus.idx_valid  = r_idx_valid;
  assign bus.idx        = r_idx;
  assign bus.rail_err   = r_rail_err;
  assign bus.step_err   = r_step_err;
  assign bus.seq_err    = r_seq_err;
  assign bus.fault      = (r_state == StFault);
  assign bus.walk_done  = r_walk_done;
  assign bus.word_count = r_word_count;

endmodule
